cgra_cfg_loader: RTL

Configuration writer for the PE array. Accepts a 4-bit nibble stream from the chip pins over a valid/ready handshake, assembles one 8-bit control word per PE, and drives every PE's `ctrl_signals_in` and `en` inputs. It double-buffers the configuration: new words are loaded into a shadow bank and committed to the live bank atomically, so a running array keeps its old configuration until the reload completes.

---
 rtl/cgra_cfg_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cgra_cfg_loader.sv
// cgra_cfg_loader: assembles 8-bit PE control words from a 4-bit nibble
// stream and commits them atomically from a shadow bank to the live bank.
// Optional feature macro: CFG_CHECKSUM_EN adds an XOR checksum nibble after
// the data phase (CHK state); the default build has no CHK and cfg_error = 0.
//
// Handshake: a nibble transfers at a rising clock edge when cfg_valid and
// cfg_ready are both 1. cfg_ready depends on the FSM state only (never on
// cfg_valid); the source holds cfg_data stable while cfg_valid is 1 and
// not yet accepted.
module cgra_cfg_loader #(
   parameter int NUM_PE = 4,
   parameter int CTRL_W = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [3:0]                 cfg_data,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   output logic [CTRL_W*NUM_PE-1:0]   ctrl_signals_out,
   output logic [NUM_PE-1:0]          pe_en,
   output logic                       busy,
   output logic                       cfg_loaded,
   output logic                       cfg_error,
   output logic [2:0]                 fsm_state
);

   localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

   localparam logic [3:0] CMD_LOAD = 4'hA;
   localparam logic [3:0] CMD_RUN  = 4'h3;
   localparam logic [3:0] CMD_HALT = 4'h5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HI     = 3'd1,
      S_LO     = 3'd2,
`ifdef CFG_CHECKSUM_EN
      S_CHK    = 3'd3,
`endif
      S_COMMIT = 3'd4
   } state_t;

   state_t                     state, next_state;
   logic                       accept;
   logic [IDX_W-1:0]           idx;
   logic [CTRL_W*NUM_PE-1:0]   shadow;
   logic [CTRL_W*NUM_PE-1:0]   live;
   logic                       run;
   logic                       loaded;

`ifdef CFG_CHECKSUM_EN
   logic [3:0]                 acc;
   logic                       err;
`endif

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state logic and handshake acceptance.
   always_comb begin
      next_state = state;
      cfg_ready  = (state != S_COMMIT);
      accept     = cfg_valid && cfg_ready;
      case (state)
         S_IDLE: begin
            if (accept && cfg_data == CMD_LOAD) next_state = S_HI;
         end
         S_HI: begin
            if (accept) next_state = S_LO;
         end
         S_LO: begin
            if (accept) begin
               if (idx != LAST_IDX) next_state = S_HI;
`ifdef CFG_CHECKSUM_EN
               else                 next_state = S_CHK;
`else
               else                 next_state = S_COMMIT;
`endif
            end
         end
`ifdef CFG_CHECKSUM_EN
         S_CHK: begin
            if (accept) next_state = (cfg_data == acc) ? S_COMMIT : S_IDLE;
         end
`endif
         S_COMMIT: next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Datapath: command handling, shadow fill, index and atomic commit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx    <= '0;
         shadow <= '0;
         live   <= '0;
         run    <= 1'b0;
         loaded <= 1'b0;
`ifdef CFG_CHECKSUM_EN
         acc    <= 4'h0;
         err    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (cfg_data == CMD_LOAD) begin
                     idx <= '0;
`ifdef CFG_CHECKSUM_EN
                     acc <= 4'h0;
                     err <= 1'b0;
`endif
                  end else if (cfg_data == CMD_RUN) begin
                     if (loaded) run <= 1'b1;
                  end else if (cfg_data == CMD_HALT) begin
                     run <= 1'b0;
                  end
               end
            end
            S_HI: begin
               if (accept) begin
                  shadow[{idx, 3'b100} +: 4] <= cfg_data;
`ifdef CFG_CHECKSUM_EN
                  acc <= acc ^ cfg_data;
`endif
               end
            end
            S_LO: begin
               if (accept) begin
                  shadow[{idx, 3'b000} +: 4] <= cfg_data;
`ifdef CFG_CHECKSUM_EN
                  acc <= acc ^ cfg_data;
`endif
                  if (idx != LAST_IDX) idx <= idx + 1'b1;
               end
            end
`ifdef CFG_CHECKSUM_EN
            S_CHK: begin
               if (accept && cfg_data != acc) err <= 1'b1;
            end
`endif
            S_COMMIT: begin
               live   <= shadow;
               loaded <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ctrl_signals_out = live;
   assign pe_en            = {NUM_PE{run}};
   assign busy             = (state != S_IDLE);
   assign cfg_loaded       = loaded;
   assign fsm_state        = state;
`ifdef CFG_CHECKSUM_EN
   assign cfg_error        = err;
`else
   assign cfg_error        = 1'b0;
`endif

endmodule
